// File: rtl/fb_pixel_writer_pkg.sv
// ============================================================================
//  Package     : fb_pkg
//  Description : Shared types and default geometry for the framebuffer writer.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fb_pkg;

  localparam int FB_H_RES  = 320;
  localparam int FB_V_RES  = 200;
  localparam int FB_ADDR_W = 16;
  localparam int FB_DATA_W = 24;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  typedef enum logic [1:0] {
    FB_IDLE  = 2'd0,
    FB_WRITE = 2'd1,
    FB_DONE  = 2'd2
  } fb_state_e;

  function automatic rgb_t fb_pack_rgb(input logic [7:0] r, input logic [7:0] g,
                                       input logic [7:0] b);
    rgb_t p;
    p.r = r;
    p.g = g;
    p.b = b;
    return p;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fb_pixel_writer_if.sv
// ============================================================================
//  Interface   : fb_pixel_writer_if
//  Description : Pixel stream in, BRAM port-B write out. Optional macro
//                FB_WRITE_DOUBLE_BUFFER_EN adds a bank bit and o_bank.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface fb_pixel_writer_if
  import fb_pkg::*;
#(
  parameter int ADDR_W = FB_ADDR_W,
  parameter int DATA_W = FB_DATA_W
);

`ifdef FB_WRITE_DOUBLE_BUFFER_EN
  localparam int C_ADDRB_W = ADDR_W + 1;
`else
  localparam int C_ADDRB_W = ADDR_W;
`endif

  logic                 i_valid;
  logic                 o_ready;
  logic                 i_sof;
  logic                 i_eol;
  logic [DATA_W-1:0]    i_rgb;
  logic                 i_fb_lock;
  logic                 o_web;
  logic [C_ADDRB_W-1:0] o_addrb;
  logic [DATA_W-1:0]    o_dinb;
  logic                 o_frame_done;
  logic                 o_line_err;
  logic                 o_sof_err;
`ifdef FB_WRITE_DOUBLE_BUFFER_EN
  logic                 o_bank;
`endif

  modport master (
    output i_valid, i_sof, i_eol, i_rgb, i_fb_lock,
    input  o_ready, o_web, o_addrb, o_dinb, o_frame_done, o_line_err, o_sof_err
`ifdef FB_WRITE_DOUBLE_BUFFER_EN
    , o_bank
`endif
  );

  modport slave (
    input  i_valid, i_sof, i_eol, i_rgb, i_fb_lock,
    output o_ready, o_web, o_addrb, o_dinb, o_frame_done, o_line_err, o_sof_err
`ifdef FB_WRITE_DOUBLE_BUFFER_EN
    , o_bank
`endif
  );

endinterface

`default_nettype wire

// File: rtl/fb_addr_gen.sv
// ============================================================================
//  Module      : fb_addr_gen
//  Description : Column/row counters and incremental linear address
//                (row_base + x) without a multiplier.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fb_addr_gen
  import fb_pkg::*;
#(
  parameter int H_RES  = FB_H_RES,
  parameter int V_RES  = FB_V_RES,
  parameter int ADDR_W = FB_ADDR_W
) (
  input  wire logic              clk,
  input  wire logic              rst,
  input  wire logic              i_start,
  input  wire logic              i_step,
  input  wire logic              i_line_done,
  output logic [ADDR_W-1:0]      o_addr,
  output logic                   o_x_last,
  output logic                   o_y_last
);

  localparam int C_X_W = (H_RES > 1) ? $clog2(H_RES) : 1;
  localparam int C_Y_W = (V_RES > 1) ? $clog2(V_RES) : 1;
  localparam logic [C_X_W-1:0]  c_x_max = C_X_W'(H_RES - 1);
  localparam logic [C_Y_W-1:0]  c_y_max = C_Y_W'(V_RES - 1);
  localparam logic [ADDR_W-1:0] c_h_res = ADDR_W'(H_RES);

  logic [C_X_W-1:0]  r_x;
  logic [C_Y_W-1:0]  r_y;
  logic [ADDR_W-1:0] r_row_base;
  logic [ADDR_W-1:0] r_addr;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_x        <= '0;
      r_y        <= '0;
      r_row_base <= '0;
      r_addr     <= '0;
    end else if (i_start) begin
      // The start-of-frame pixel itself lands at 0, so the next one is column 1.
      r_x        <= C_X_W'(1);
      r_y        <= '0;
      r_row_base <= '0;
      r_addr     <= ADDR_W'(1);
    end else if (i_step) begin
      if (i_line_done) begin
        if (o_y_last) begin
          r_x        <= '0;
          r_y        <= '0;
          r_row_base <= '0;
          r_addr     <= '0;
        end else begin
          r_x        <= '0;
          r_y        <= r_y + 1'b1;
          r_row_base <= r_row_base + c_h_res;
          r_addr     <= r_row_base + c_h_res;
        end
      end else begin
        r_x    <= r_x + 1'b1;
        r_addr <= r_addr + 1'b1;
      end
    end
  end

  assign o_addr   = r_addr;
  assign o_x_last = (r_x == c_x_max);
  assign o_y_last = (r_y == c_y_max);

endmodule

`default_nettype wire

// File: rtl/fb_pixel_writer.sv
// ============================================================================
//  Module      : fb_pixel_writer
//  Description : Pixel stream to framebuffer BRAM write port with protocol
//                error flags. Optional macro FB_WRITE_DOUBLE_BUFFER_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fb_pixel_writer
  import fb_pkg::*;
#(
  parameter int H_RES  = FB_H_RES,
  parameter int V_RES  = FB_V_RES,
  parameter int ADDR_W = FB_ADDR_W,
  parameter int DATA_W = FB_DATA_W
) (
  input  wire logic        clk,
  input  wire logic        rst,
  fb_pixel_writer_if.slave bus
);

  localparam logic [1:0] c_st_idle  = FB_IDLE;
  localparam logic [1:0] c_st_write = FB_WRITE;
  localparam logic [1:0] c_st_done  = FB_DONE;

  logic [1:0]        r_state;
  logic              r_web;
  logic [ADDR_W-1:0] r_addrb;
  logic [DATA_W-1:0] r_dinb;
  logic              r_frame_done;
  logic              r_line_err;
  logic              r_sof_err;

  logic              w_ready;
  logic              w_accept;
  logic              w_sof_acc;
  logic              w_step;
  logic              w_line_done;
  logic [ADDR_W-1:0] w_addr;
  logic              w_x_last;
  logic              w_y_last;

  assign w_ready     = !bus.i_fb_lock & ((r_state == c_st_idle) | (r_state == c_st_write));
  assign w_accept    = bus.i_valid & w_ready;
  assign w_sof_acc   = w_accept & bus.i_sof;
  // sof wins over eol, so a step is only a non-sof beat inside a frame.
  assign w_step      = w_accept & !bus.i_sof & (r_state == c_st_write);
  assign w_line_done = w_step & (w_x_last | bus.i_eol);

  fb_addr_gen #(
    .H_RES  (H_RES),
    .V_RES  (V_RES),
    .ADDR_W (ADDR_W)
  ) u_addr_gen (
    .clk         (clk),
    .rst         (rst),
    .i_start     (w_sof_acc),
    .i_step      (w_step),
    .i_line_done (w_line_done),
    .o_addr      (w_addr),
    .o_x_last    (w_x_last),
    .o_y_last    (w_y_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= c_st_idle;
      r_web        <= 1'b0;
      r_addrb      <= '0;
      r_dinb       <= '0;
      r_frame_done <= 1'b0;
      r_line_err   <= 1'b0;
      r_sof_err    <= 1'b0;
    end else begin
      r_web        <= w_sof_acc | w_step;
      r_line_err   <= w_step & (w_x_last ^ bus.i_eol);
      r_sof_err    <= w_sof_acc & (r_state == c_st_write);
      r_frame_done <= (r_state == c_st_done);
      if (w_sof_acc | w_step) begin
        r_addrb <= w_sof_acc ? '0 : w_addr;
        r_dinb  <= bus.i_rgb;
      end
      case (r_state)
        c_st_idle:  if (w_sof_acc) r_state <= c_st_write;
        c_st_write: if (w_line_done & w_y_last) r_state <= c_st_done;
        c_st_done:  r_state <= c_st_idle;
        default:    r_state <= c_st_idle;
      endcase
    end
  end

`ifdef FB_WRITE_DOUBLE_BUFFER_EN
  logic r_bank_wr;
  logic r_bank_done;

  // Bank flips together with o_frame_done, after the frame's last write.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bank_wr   <= 1'b0;
      r_bank_done <= 1'b0;
    end else if (r_state == c_st_done) begin
      r_bank_wr   <= ~r_bank_wr;
      r_bank_done <= r_bank_wr;
    end
  end

  assign bus.o_addrb = {r_bank_wr, r_addrb};
  assign bus.o_bank  = r_bank_done;
`else
  assign bus.o_addrb = r_addrb;
`endif

  assign bus.o_ready      = w_ready;
  assign bus.o_web        = r_web;
  assign bus.o_dinb       = r_dinb;
  assign bus.o_frame_done = r_frame_done;
  assign bus.o_line_err   = r_line_err;
  assign bus.o_sof_err    = r_sof_err;

endmodule

`default_nettype wire

// File: tb/tb_fb_pixel_writer.sv
// ============================================================================
//  Module      : tb_fb_pixel_writer
//  Description : Scoreboard bench for fb_pixel_writer (320-pixel lines, short
//                16-line frames); honours FB_WRITE_DOUBLE_BUFFER_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fb_pixel_writer;
  import fb_pkg::*;

  localparam int H  = 320;
  localparam int V  = 16;
  localparam int AW = FB_ADDR_W;
  localparam int DW = FB_DATA_W;
`ifdef FB_WRITE_DOUBLE_BUFFER_EN
  localparam int OAW = AW + 1;
`else
  localparam int OAW = AW;
`endif

  typedef struct {
    int              cyc;
    logic [OAW-1:0]  addr;
    logic [DW-1:0]   data;
    logic            le;
    logic            se;
  } wr_t;

  typedef struct {
    int   cyc;
    logic bank;
  } fd_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_fail = 0;

  wr_t  wq[$];
  fd_t  fq[$];
  wr_t  m_e;
  fd_t  m_f;
  logic m_bank_ok;

  logic m_active = 1'b0;
  int   m_x = 0;
  int   m_y = 0;
  logic m_bank = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fb_pixel_writer_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  fb_pixel_writer #(.H_RES(H), .V_RES(V), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic logic [DW-1:0] pix(input int f, input int y, input int x);
    rgb_t p;
    logic [19:0] lin;
    lin = 20'(y * H + x);
    p = fb_pack_rgb({f[3:0], lin[19:16]}, lin[15:8], lin[7:0]);
    return p;
  endfunction

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (bus.o_web) begin
      if (wq.size() == 0) begin
        n_vec++; n_fail++;
        $display("FAIL unexpected_write: cyc=%0d addr=%0h data=%06h, required no write",
                 cyc, bus.o_addrb, bus.o_dinb);
      end else begin
        m_e = wq.pop_front();
        n_vec++;
        if (bus.o_addrb !== m_e.addr || bus.o_dinb !== m_e.data ||
            bus.o_line_err !== m_e.le || bus.o_sof_err !== m_e.se || cyc != m_e.cyc) begin
          n_fail++;
          $display("FAIL write: cyc=%0d addr=%0h data=%06h le=%b se=%b, required cyc=%0d addr=%0h data=%06h le=%b se=%b",
                   cyc, bus.o_addrb, bus.o_dinb, bus.o_line_err, bus.o_sof_err,
                   m_e.cyc, m_e.addr, m_e.data, m_e.le, m_e.se);
        end
      end
    end else if (bus.o_line_err || bus.o_sof_err) begin
      n_vec++; n_fail++;
      $display("FAIL stray_err: cyc=%0d le=%b se=%b without write, required 0 0",
               cyc, bus.o_line_err, bus.o_sof_err);
    end
    if (bus.o_frame_done) begin
      if (fq.size() == 0) begin
        n_vec++; n_fail++;
        $display("FAIL unexpected_frame_done: cyc=%0d, required none", cyc);
      end else begin
        m_f = fq.pop_front();
        n_vec++;
`ifdef FB_WRITE_DOUBLE_BUFFER_EN
        m_bank_ok = (bus.o_bank === m_f.bank);
`else
        m_bank_ok = 1'b1;
`endif
        if (cyc != m_f.cyc || !m_bank_ok) begin
          n_fail++;
          $display("FAIL frame_done: cyc=%0d bank_ok=%b, required cyc=%0d bank=%b",
                   cyc, m_bank_ok, m_f.cyc, m_f.bank);
        end
      end
    end
  end

  // ---------------- reference model ----------------
  task automatic push_wr(input int c, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input logic le, input logic se);
    wr_t e;
    e.cyc = c + 1;
`ifdef FB_WRITE_DOUBLE_BUFFER_EN
    e.addr = {m_bank, a};
`else
    e.addr = a;
`endif
    e.data = d;
    e.le   = le;
    e.se   = se;
    wq.push_back(e);
  endtask

  task automatic model_accept(input logic sof, input logic eol, input logic [DW-1:0] rgb,
                              input int c);
    fd_t f;
    if (sof) begin
      push_wr(c, '0, rgb, 1'b0, m_active);
      m_active = 1'b1;
      m_x = 1;
      m_y = 0;
    end else if (m_active) begin
      push_wr(c, AW'(m_y * H + m_x), rgb, (m_x == H - 1) != eol, 1'b0);
      if (m_x == H - 1 || eol) begin
        m_x = 0;
        if (m_y == V - 1) begin
          m_y = 0;
          m_active = 1'b0;
          f.cyc  = c + 2;
          f.bank = m_bank;
          fq.push_back(f);
          m_bank = ~m_bank;
        end else begin
          m_y++;
        end
      end else begin
        m_x++;
      end
    end
  endtask

  // ---------------- drivers ----------------
  task automatic send(input logic sof, input logic eol, input logic [DW-1:0] rgb);
    int waits;
    bus.i_valid = 1'b1;
    bus.i_sof   = sof;
    bus.i_eol   = eol;
    bus.i_rgb   = rgb;
    waits = 0;
    @(negedge clk);
    while (!bus.o_ready && waits < 20) begin
      @(negedge clk);
      waits++;
    end
    if (!bus.o_ready) begin
      n_vec++; n_fail++;
      $display("FAIL handshake: o_ready=0 for %0d cycles, required 1", waits);
    end else begin
      model_accept(sof, eol, rgb, cyc);
    end
    @(posedge clk); #1;
    bus.i_valid = 1'b0;
    bus.i_sof   = 1'b0;
    bus.i_eol   = 1'b0;
  endtask

  task automatic do_lock();
    @(posedge clk); #1;
    bus.i_fb_lock = 1'b1;
    bus.i_valid   = 1'b1;
    bus.i_rgb     = 24'hDEAD00;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      n_vec++;
      if (bus.o_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL lock_ready[%0d]: o_ready=%b, required 0", i, bus.o_ready);
      end
      n_vec++;
      if (bus.o_web !== 1'b0) begin
        n_fail++;
        $display("FAIL lock_web[%0d]: o_web=%b, required 0", i, bus.o_web);
      end
      @(posedge clk); #1;
    end
    bus.i_fb_lock = 1'b0;
    bus.i_valid   = 1'b0;
  endtask

  // sy/sx: short line (eol early); ry/rx: restart with sof+eol; ly/lx: lock before beat.
  task automatic send_frame(input int f, input int sy, input int sx, input int ry,
                            input int rx, input int ly, input int lx);
    int   x, y, rsy;
    logic eol;
    rsy = ry;
    send(1'b1, 1'b0, pix(f, 0, 0));
    x = 1;
    y = 0;
    while (y < V) begin
      if (y == ly && x == lx) do_lock();
      if (y == rsy && x == rx) begin
        send(1'b1, 1'b1, pix(f + 8, y, x));
        rsy = -1;
        x = 1;
        y = 0;
      end else begin
        eol = (x == H - 1) || (y == sy && x == sx);
        send(1'b0, eol, pix(f, y, x));
        if (eol) begin
          x = 0;
          y++;
        end else begin
          x++;
        end
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.i_valid   = 1'b0;
    bus.i_sof     = 1'b0;
    bus.i_eol     = 1'b0;
    bus.i_rgb     = '0;
    bus.i_fb_lock = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 32'(bus.o_ready), 32'd1);
    chk("rst_web", 32'(bus.o_web), 32'd0);
    chk("rst_addrb", 32'(bus.o_addrb), 32'd0);
    chk("rst_dinb", 32'(bus.o_dinb), 32'd0);
    chk("rst_frame_done", 32'(bus.o_frame_done), 32'd0);
    chk("rst_line_err", 32'(bus.o_line_err), 32'd0);
    chk("rst_sof_err", 32'(bus.o_sof_err), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Beats before the first sof are dropped.
    for (int i = 0; i < 5; i++) send(1'b0, i == 4, pix(15, 0, i));
    // Frame 1: full frame.
    send_frame(1, -1, 0, -1, 0, -1, 0);
    // Frame 2: line 3 ends at x=99.
    send_frame(2, 3, 99, -1, 0, -1, 0);
    // Frame 3: sof (with eol) arrives at y=10, x=50.
    send_frame(3, -1, 0, 10, 50, -1, 0);
    // Frame 4: lock for 7 cycles mid-line.
    send_frame(4, -1, 0, -1, 0, 5, 123);

    // Reset mid-frame; following non-sof beats must not be written.
    send(1'b1, 1'b0, pix(5, 0, 0));
    for (int i = 1; i < 10; i++) send(1'b0, 1'b0, pix(5, 0, i));
    rst = 1'b1;
    m_active = 1'b0;
    m_x = 0;
    m_y = 0;
    m_bank = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) send(1'b0, 1'b0, pix(6, 0, i));
    send(1'b1, 1'b0, pix(7, 0, 0));
    send(1'b0, 1'b0, pix(7, 0, 1));
    send(1'b0, 1'b0, pix(7, 0, 2));

    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("pending_writes", 32'(wq.size()), 32'd0);
    chk("pending_frame_done", 32'(fq.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
